cart_mem_arbiter: RTL

CART_MEM_ARBITER -- requirements
Module: cart_mem_arbiter

---
 rtl/cart_mem_pkg.sv | 19 +
 rtl/cart_mem_arbiter_if.sv | 32 +++
 rtl/dl_wr_fifo.sv | 59 +++++
 rtl/cart_mem_arbiter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/cart_mem_pkg.sv
// Shared types and constants for the cartridge/download SDRAM arbiter.
package cart_mem_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE_WR,
      ST_ISSUE_RD,
      ST_WAIT_LO,
      ST_WAIT_HI
   } state_e;

   typedef struct packed {
      logic [24:0] addr;
      logic [7:0]  data;
   } wr_entry_t;

   localparam logic [7:0] OPEN_BUS = 8'hFF;

endpackage

// File: rtl/cart_mem_arbiter_if.sv
// Download, cartridge-read and SDRAM signals of the arbiter.
// The arbiter uses the slave view; its environment uses the master view.
interface cart_mem_arbiter_if;

   logic        dl_active;
   logic        dl_wr;
   logic [24:0] dl_addr;
   logic [7:0]  dl_data;
   logic        dl_wait;
   logic        cart_rd;
   logic [19:0] cart_addr;
   logic [7:0]  cart_data;
   logic        cart_valid;
   logic [24:0] mem_addr;
   logic [7:0]  mem_din;
   logic        mem_we;
   logic        mem_rd;
   logic        mem_ready;
   logic [7:0]  mem_dout;
   logic        err;

   modport slave (
      input  dl_active, dl_wr, dl_addr, dl_data, cart_rd, cart_addr, mem_ready, mem_dout,
      output dl_wait, cart_data, cart_valid, mem_addr, mem_din, mem_we, mem_rd, err
   );

   modport master (
      output dl_active, dl_wr, dl_addr, dl_data, cart_rd, cart_addr, mem_ready, mem_dout,
      input  dl_wait, cart_data, cart_valid, mem_addr, mem_din, mem_we, mem_rd, err
   );

endinterface

// File: rtl/dl_wr_fifo.sv
// Download write buffer.
// A circular FIFO of {addr, data} entries with an occupancy counter.
module dl_wr_fifo
   import cart_mem_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic      clk_sys,
   input  logic      reset,
   input  logic      push_i,
   input  wr_entry_t entry_i,
   input  logic      pop_i,
   output wr_entry_t head_o,
   output logic      full_o,
   output logic      empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   wr_entry_t        mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign head_o  = mem_q[rd_ptr_q];

   // NOTE: the storage array has no reset; occupancy alone decides which entries are live.
   always_ff @(posedge clk_sys) begin
      if (do_push) mem_q[wr_ptr_q] <= entry_i;
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/cart_mem_arbiter.sv
// Shares one SDRAM port between buffered download writes and cartridge reads.
// Reads are served from a one-entry cache when possible.
module cart_mem_arbiter
   import cart_mem_pkg::*;
#(
   parameter int TIMEOUT    = 63,
   parameter int FIFO_DEPTH = 2
) (
   input  logic               clk_sys,
   input  logic               reset,
   cart_mem_arbiter_if.slave  bus
);

   localparam int TMO_W = $clog2(TIMEOUT + 1);

   state_e           state_q;
   logic [TMO_W-1:0] tmo_cnt_q;
   logic             op_rd_q;
   logic             rd_pend_q;
   logic [19:0]      rd_req_addr_q;
   logic [19:0]      rd_cur_addr_q;
   logic             cache_vld_q;
   logic [19:0]      cache_addr_q;
   logic [7:0]       cache_data_q;
   logic [7:0]       cart_data_q;
   logic             cart_valid_q;
   logic [24:0]      mem_addr_q;
   logic [7:0]       mem_din_q;
   logic             mem_we_q;
   logic             mem_rd_q;
   logic             err_q;

   wr_entry_t        fifo_in;
   wr_entry_t        fifo_head;
   logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic             in_wait, wait_done, tmo_hit;
   logic             cache_hit, rd_miss, rd_go, rd_issue, rd_busy;
   logic [19:0]      rd_addr_sel;

   dl_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_sys (clk_sys),
      .reset   (reset),
      .push_i  (fifo_push),
      .entry_i (fifo_in),
      .pop_i   (fifo_pop),
      .head_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign fifo_in   = '{addr: bus.dl_addr, data: bus.dl_data};
   assign fifo_push = bus.dl_wr && !fifo_full;
   assign in_wait   = (state_q == ST_WAIT_LO) || (state_q == ST_WAIT_HI);
   assign wait_done = (state_q == ST_WAIT_HI) && bus.mem_ready;
   assign tmo_hit   = in_wait && !wait_done && (tmo_cnt_q == TMO_W'(TIMEOUT - 1));
   assign fifo_pop  = in_wait && !op_rd_q && (wait_done || tmo_hit);

   // A fresh miss is issued in the same cycle it arrives, which gives the 4-cycle read path.
   assign cache_hit   = bus.cart_rd && !bus.dl_active && cache_vld_q && (bus.cart_addr == cache_addr_q);
   assign rd_miss     = bus.cart_rd && !bus.dl_active && !cache_hit;
   assign rd_go       = (rd_pend_q || rd_miss) && !bus.dl_active && bus.mem_ready;
   assign rd_addr_sel = rd_miss ? bus.cart_addr : rd_req_addr_q;
   assign rd_issue    = (state_q == ST_IDLE) && fifo_empty && rd_go;
   assign rd_busy     = rd_issue || (state_q == ST_ISSUE_RD) || (in_wait && op_rd_q);

   // NOTE: every register here uses <=, so a later assignment in this block wins over an earlier one.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         tmo_cnt_q     <= '0;
         op_rd_q       <= 1'b0;
         rd_pend_q     <= 1'b0;
         rd_req_addr_q <= '0;
         rd_cur_addr_q <= '0;
         cache_vld_q   <= 1'b0;
         cache_addr_q  <= '0;
         cache_data_q  <= '0;
         cart_data_q   <= OPEN_BUS;
         cart_valid_q  <= 1'b0;
         mem_addr_q    <= '0;
         mem_din_q     <= '0;
         mem_we_q      <= 1'b0;
         mem_rd_q      <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         mem_we_q     <= 1'b0;
         mem_rd_q     <= 1'b0;
         cart_valid_q <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               if (!fifo_empty && bus.mem_ready) begin
                  state_q    <= ST_ISSUE_WR;
                  op_rd_q    <= 1'b0;
                  mem_we_q   <= 1'b1;
                  mem_addr_q <= fifo_head.addr;
                  mem_din_q  <= fifo_head.data;
               end else if (rd_go) begin
                  state_q       <= ST_ISSUE_RD;
                  op_rd_q       <= 1'b1;
                  mem_rd_q      <= 1'b1;
                  mem_addr_q    <= {5'd0, rd_addr_sel};
                  rd_cur_addr_q <= rd_addr_sel;
               end
            end
            ST_ISSUE_WR, ST_ISSUE_RD: begin
               state_q   <= ST_WAIT_LO;
               tmo_cnt_q <= '0;
            end
            ST_WAIT_LO, ST_WAIT_HI: begin
               if (wait_done) begin
                  state_q <= ST_IDLE;
                  if (op_rd_q) begin
                     cart_data_q  <= bus.mem_dout;
                     cart_valid_q <= 1'b1;
                     rd_pend_q    <= 1'b0;
                     cache_vld_q  <= 1'b1;
                     cache_addr_q <= rd_cur_addr_q;
                     cache_data_q <= bus.mem_dout;
                  end
               end else if (tmo_hit) begin
                  state_q     <= ST_IDLE;
                  err_q       <= 1'b1;
                  cache_vld_q <= 1'b0;
                  if (op_rd_q) begin
                     cart_data_q  <= OPEN_BUS;
                     cart_valid_q <= 1'b1;
                     rd_pend_q    <= 1'b0;
                  end
               end else begin
                  if ((state_q == ST_WAIT_LO) && !bus.mem_ready) state_q <= ST_WAIT_HI;
                  tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase

         // Request side comes last so a new cart_rd survives a completion in the same cycle.
         if (rd_miss) begin
            rd_pend_q     <= 1'b1;
            rd_req_addr_q <= bus.cart_addr;
         end else if (bus.cart_rd) begin
            cart_data_q  <= bus.dl_active ? OPEN_BUS : cache_data_q;
            cart_valid_q <= 1'b1;
            if (!rd_busy) rd_pend_q <= 1'b0;
         end
         if (fifo_push) cache_vld_q <= 1'b0;
      end
   end

   assign bus.dl_wait    = fifo_full;
   assign bus.cart_data  = cart_data_q;
   assign bus.cart_valid = cart_valid_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_din    = mem_din_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_rd     = mem_rd_q;
   assign bus.err        = err_q;

endmodule
